dm_arbiter: RTL
===============

# dm_arbiter

Single-port data-memory arbiter between the pipeline M stage (CPU port) and a burst DMA/debug-loader port. Sits in front of the DM block and owns its address, write-enable and write-data inputs. It schedules one DM access per cycle, gives the CPU priority, and guarantees the DMA one slot after every STARVE_LIMIT consecutive CPU slots. When the CPU loses a slot, the arbiter stalls the pipeline.

## Interface
- STARVE_LIMIT, 4: maximum consecutive CPU-owned slots while a DMA burst is pending (range 1..15).
- Clk  in  1  clock; all state updates on posedge.
- Reset  in  1  synchronous, active-high.
- cpu_req  in  1  M stage wants DM this cycle (load or store).
- cpu_we  in  4  CPU byte write enables; 0 means read.
- cpu_addr  in  32  CPU byte address, passed to DM unchanged.
- cpu_wdata  in  32  CPU store data.
- cpu_stall  out  1  CPU slot denied this cycle; pipeline must hold M stage.
- cpu_rdata  out  32  combinational copy of dm_rdata.
- dma_req  in  1  start-burst strobe, sampled only in IDLE.
- dma_wr  in  1  burst direction, 1 = write to DM; latched at start.
- dma_base  in  32  burst start address; bits [1:0] ignored and forced to 00.
- dma_len  in  8  number of word beats, 1..255; 0 means the request is ignored.
- dma_wdata  in  32  write data for the current beat.
- dma_wready  out  1  a write beat is issued this cycle and dma_wdata is consumed.
- dma_rdata  out  32  registered read beat data.
- dma_rvalid  out  1  dma_rdata holds a new beat; one-cycle pulse per beat.
- dma_busy  out  1  burst active.
- dma_done  out  1  one-cycle pulse after the last beat.
- dm_addr  out  32  DM address.
- dm_we  out  4  DM byte write enables.
- dm_wdata  out  32  DM write data.
- dm_rdata  in  32  DM combinational read data.

## Operation
- States:
  - IDLE: no burst. CPU owns every slot.
  - ACTIVE: burst in progress.
- Internal registers:
  - addr_q (32): next DMA beat address.
  - left_q (8): beats remaining.
  - wr_q: latched burst direction.
  - starve_q (4): consecutive CPU slots taken while a beat is pending.
- IDLE -> ACTIVE when dma_req=1 and dma_len!=0. On that transition: addr_q={dma_base[31:2],2'b00}, left_q=dma_len, wr_q=dma_wr, starve_q=0.
- Slot decision in ACTIVE (combinational):
  - grant_dma = !cpu_req or starve_q==STARVE_LIMIT.
  - Otherwise the CPU gets the slot.
- CPU slot:
  - DM mux: dm_addr=cpu_addr, dm_we=cpu_req?cpu_we:0, dm_wdata=cpu_wdata.
  - Counter: starve_q increments only when cpu_req=1.
- DMA slot:
  - DM mux: dm_addr=addr_q, dm_we=wr_q?4'hF:4'h0, dm_wdata=dma_wdata.
  - Handshake: dma_wready=wr_q.
  - Counters: addr_q+=4 (mod 2^32, wraps 0xFFFFFFFC->0x00000000), left_q-=1, starve_q=0.
- Read beats: dma_rdata<=dm_rdata and dma_rvalid<=1 at the edge ending the DMA read slot. Otherwise dma_rvalid<=0 and dma_rdata holds its value.
- cpu_stall = cpu_req & grant_dma & ACTIVE. It is never asserted in IDLE.
- Burst end: the DMA slot with left_q==1 moves ACTIVE->IDLE at that edge and sets dma_done<=1 for exactly one cycle.
- dma_busy = (state==ACTIVE).
- Ignored inputs:
  - dma_req in ACTIVE is ignored.
  - dma_base, dma_len and dma_wr changes during a burst have no effect.
- cpu_rdata=dm_rdata in every cycle. It is valid to the CPU only when cpu_stall=0.

## Timing
- Reset values: state IDLE; addr_q, left_q, starve_q, wr_q all 0.
- Reset output values: dma_rdata=0, dma_rvalid=0, dma_done=0, dma_busy=0, dma_wready=0, cpu_stall=0.
- While Reset=1, dm_we is forced to 0.
- Reset mid-burst: the burst is aborted at that edge. No dma_done pulse. No DM writes after the edge.
- Acceptance: dma_req sampled at edge T; dma_busy=1 from T. The first possible beat is the cycle after T.
- With cpu_req=0, an N-beat burst occupies N consecutive cycles. dma_done pulses in the cycle after the last beat, with dma_busy=0 in that same cycle.
- A new dma_req is accepted in the cycle dma_done is high, since the state is IDLE.
- Worst-case CPU impact: one stall cycle per STARVE_LIMIT+1 cycles.
- Worst-case DMA beat latency: STARVE_LIMIT+1 cycles.
- Read data: dma_rvalid is high one cycle after its read slot.

## Test plan
- After Reset, CPU read at 0x10: dm_addr=0x10, dm_we=0, cpu_stall=0, cpu_rdata=dm_rdata. Then CPU store with we=4'h3 at 0x14 -> dm_we=4'h3 that cycle.
- DMA write burst (base 0x103, len 3, cpu_req=0):
  - Beats go to 0x100, 0x104 and 0x108 on 3 consecutive cycles, with dm_we=4'hF and dma_wready=1 on each.
  - dma_done pulses next cycle; dma_busy then 0.
- Contention (STARVE_LIMIT=4, cpu_req held 1, DMA read burst len 2):
  - Slot pattern is C,C,C,C,D,C,C,C,C,D.
  - cpu_stall=1 only on the D cycles.
  - dma_rvalid pulses one cycle after each D slot with the DM data.
  - dma_done pulses after the second beat.
- Wrap: base 0xFFFFFFFC, len 2 -> beat addresses 0xFFFFFFFC, then 0x00000000.
- Reset asserted after beat 1 of a len-4 write burst: dma_busy=0 from that edge, no dma_done, no further dm_we≠0. A subsequent dma_req with len 0 leaves dma_busy=0.
- Requests while busy: dma_req pulsed during an active burst with a different base/len has no effect; the original burst completes unchanged with exactly one dma_done.

Source files
------------

// File: rtl/dm_arbiter.sv
// dm_arbiter: single-port data-memory arbiter between the M-stage CPU port
// and a burst DMA/loader port; CPU has priority with a bounded starvation window.
module dm_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        cpu_req,
  input  logic [3:0]  cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_stall,
  output logic [31:0] cpu_rdata,
  input  logic        dma_req,
  input  logic        dma_wr,
  input  logic [31:0] dma_base,
  input  logic [7:0]  dma_len,
  input  logic [31:0] dma_wdata,
  output logic        dma_wready,
  output logic [31:0] dma_rdata,
  output logic        dma_rvalid,
  output logic        dma_busy,
  output logic        dma_done,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_we,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  localparam logic [3:0] LIMIT = STARVE_LIMIT[3:0];

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  left_q, left_d;
  logic        wr_q, wr_d;
  logic [3:0]  starve_q, starve_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;
  logic        done_q, done_d;
  logic        grant_dma;

  // Register all arbiter state; synchronous reset aborts any burst.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      left_q   <= '0;
      wr_q     <= 1'b0;
      starve_q <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      left_q   <= left_d;
      wr_q     <= wr_d;
      starve_q <= starve_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      done_q   <= done_d;
    end
  end

  // Slot decision, DM mux, handshakes and next-state for the burst engine.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    left_d   = left_q;
    wr_d     = wr_q;
    starve_d = starve_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    done_d   = 1'b0;

    grant_dma = (state_q == ACTIVE) &&
                (!cpu_req || starve_q == LIMIT);

    if (grant_dma) begin
      dm_addr  = addr_q;
      dm_we    = wr_q ? 4'hF : 4'h0;
      dm_wdata = dma_wdata;
    end else begin
      dm_addr  = cpu_addr;
      dm_we    = cpu_req ? cpu_we : 4'h0;
      dm_wdata = cpu_wdata;
    end
    if (Reset) dm_we = 4'h0;

    cpu_stall  = cpu_req & grant_dma;
    dma_wready = grant_dma & wr_q;

    unique case (state_q)
      IDLE: begin
        if (dma_req && dma_len != 8'd0) begin
          state_d  = ACTIVE;
          addr_d   = dma_base & ~32'h3;
          left_d   = dma_len;
          wr_d     = dma_wr;
          starve_d = 4'd0;
        end
      end
      ACTIVE: begin
        if (grant_dma) begin
          addr_d   = addr_q + 32'd4;
          left_d   = left_q - 8'd1;
          starve_d = 4'd0;
          if (!wr_q) begin
            rdata_d  = dm_rdata;
            rvalid_d = 1'b1;
          end
          if (left_q == 8'd1) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else if (cpu_req) begin
          starve_d = starve_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cpu_rdata  = dm_rdata;
  assign dma_rdata  = rdata_q;
  assign dma_rvalid = rvalid_q;
  assign dma_done   = done_q;
  assign dma_busy   = (state_q == ACTIVE);

endmodule
